// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI memory arbiter:
// FSM state codes, owner encoding and AXI response codes.
package axi_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the master that did not win last time is chosen.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // Reset to M1 so that M0 wins the very first tie.
  logic lastGrant_q, lastGrant_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = lastGrant_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (advance_i && gnt_o[1]) begin
      lastGrant_d = 1'b1;
    end else if (advance_i && gnt_o[0]) begin
      lastGrant_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Serialises IFU (M0, read-only) and LSU (M1, read/write) AXI traffic onto one memory
// slave, one transaction at a time, round-robin between masters, write before read in M1.
module axi_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  logic [2:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                awDone_q, awDone_d;
  logic                wDone_q, wDone_d;

  logic       req0, req1, wreq1, advance;
  logic [1:0] gnt;

  // AW and W are only ever accepted together, so a lone AW is not a write request.
  assign req0    = m0_arvalid;
  assign wreq1   = m1_awvalid & m1_wvalid;
  assign req1    = wreq1 | m1_arvalid;
  assign advance = (state_q == ST_IDLE) && aresetn;

  rr_arb2 u_rr_arb2 (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .req_i     ({req1, req0}),
    .advance_i (advance),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awDone_d   = awDone_q;
    wDone_d    = wDone_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rdata   = s_rdata;
    m1_rresp   = s_rresp;
    m1_bresp   = s_bresp;
    s_araddr   = addr_q;
    s_awaddr   = addr_q;
    s_wdata    = wdata_q;
    s_wstrb    = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (advance && gnt[0]) begin
          m0_arready = 1'b1;
          addr_d     = m0_araddr;
          owner_d    = OWNER_M0;
          state_d    = ST_RD_ADDR;
        end else if (advance && gnt[1]) begin
          owner_d = OWNER_M1;
          if (wreq1) begin
            m1_awready = 1'b1;
            m1_wready  = 1'b1;
            addr_d     = m1_awaddr;
            wdata_d    = m1_wdata;
            wstrb_d    = m1_wstrb;
            state_d    = ST_WR_REQ;
          end else begin
            m1_arready = 1'b1;
            addr_d     = m1_araddr;
            state_d    = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (owner_q == OWNER_M1) begin
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready) begin
          state_d = ST_IDLE;
        end
      end
      // The slave may take AW and W in either order or together.
      ST_WR_REQ: begin
        s_awvalid = !awDone_q;
        s_wvalid  = !wDone_q;
        awDone_d  = awDone_q | (s_awvalid & s_awready);
        wDone_d   = wDone_q | (s_wvalid & s_wready);
        if (awDone_d && wDone_d) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        m1_bvalid = s_bvalid;
        s_bready  = m1_bready;
        if (s_bvalid && m1_bready) begin
          state_d  = ST_IDLE;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWNER_M0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter with a small behavioural memory slave
// whose write-data acceptance can be delayed relative to the write address.
module tb_axi_mem_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] m0_araddr;
  logic        m0_arvalid, m0_arready;
  logic [63:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m1_araddr;
  logic        m1_arvalid, m1_arready;
  logic [63:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr;
  logic        m1_awvalid, m1_awready;
  logic [63:0] m1_wdata;
  logic [7:0]  m1_wstrb;
  logic        m1_wvalid, m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid, m1_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  always #5 aclk = ~aclk;

  axi_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // Behavioural slave: one-cycle read latency, optional W delay after AW.
  logic [63:0] mem [0:1023];
  logic        awSeen, wSeen;
  logic [31:0] awAddrL;
  logic [63:0] wDataL;
  logic [7:0]  wStrbL;
  int          wCnt;
  int          wDelayCfg = 0;
  logic [1:0]  rrespCfg  = 2'b00;
  logic [1:0]  brespCfg  = 2'b00;
  int          awHs = 0;
  int          wHs  = 0;

  function automatic int memIdx(input logic [31:0] a);
    return int'({22'd0, a[12:3]});
  endfunction

  assign s_arready = 1'b1;
  assign s_awready = !awSeen;
  assign s_wready  = !wSeen && (awSeen ? (wCnt == 0) : (wDelayCfg == 0));

  always @(posedge aclk) begin
    if (!aresetn) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= '0;
      awSeen   <= 1'b0;
      wSeen    <= 1'b0;
      awAddrL  <= '0;
      wDataL   <= '0;
      wStrbL   <= '0;
      wCnt     <= 0;
      mem[0]   <= 64'h00000297_00000413;
      mem[1]   <= 64'h11223344_55667788;
      mem[512] <= 64'h11111111_22222222;
    end else begin
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[memIdx(s_araddr)];
        s_rresp  <= rrespCfg;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_awvalid && s_awready) begin
        awSeen  <= 1'b1;
        awAddrL <= s_awaddr;
        wCnt    <= wDelayCfg;
        awHs    <= awHs + 1;
      end else if (wCnt != 0) begin
        wCnt <= wCnt - 1;
      end
      if (s_wvalid && s_wready) begin
        wSeen  <= 1'b1;
        wDataL <= s_wdata;
        wStrbL <= s_wstrb;
        wHs    <= wHs + 1;
      end
      if (awSeen && wSeen && !s_bvalid) begin
        for (int b = 0; b < 8; b++) begin
          if (wStrbL[b]) mem[memIdx(awAddrL)][8*b +: 8] <= wDataL[8*b +: 8];
        end
        s_bvalid <= 1'b1;
        s_bresp  <= brespCfg;
        awSeen   <= 1'b0;
        wSeen    <= 1'b0;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Master-side monitor: a grant while a transaction is still open is an error.
  logic busy = 1'b0;
  int   badGrant = 0;
  int   bHs = 0;

  always @(posedge aclk) begin
    if (!aresetn) begin
      busy <= 1'b0;
    end else begin
      if (m0_arready || m1_arready || m1_awready) begin
        if (busy) badGrant <= badGrant + 1;
        busy <= 1'b1;
      end else if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready) || (m1_bvalid && m1_bready)) begin
        busy <= 1'b0;
      end
      if (m1_bvalid && m1_bready) bHs <= bHs + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge aclk);
  endtask

  task automatic applyStimulus(input logic m0v, input logic [31:0] m0a,
                               input logic m1arv, input logic [31:0] m1ara,
                               input logic m1awv, input logic m1wv, input logic [31:0] m1awa,
                               input logic [63:0] m1wd, input logic [7:0] m1ws);
    m0_arvalid = m0v;
    m0_araddr  = m0a;
    m1_arvalid = m1arv;
    m1_araddr  = m1ara;
    m1_awvalid = m1awv;
    m1_wvalid  = m1wv;
    m1_awaddr  = m1awa;
    m1_wdata   = m1wd;
    m1_wstrb   = m1ws;
  endtask

  task automatic idleReq();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return m0_rvalid;
      1:       return m1_rvalid;
      2:       return m1_bvalid;
      3:       return m1_arready;
      default: return m0_arready;
    endcase
  endfunction

  // Advances to the next negedge repeatedly until the selected signal is high.
  task automatic waitFor(input int which, input string tag);
    int n;
    n = 0;
    sampleNow();
    while (!cond(which) && n < 60) begin
      sampleNow();
      n++;
    end
    checkOutput(tag, 64'(cond(which)), 64'h1);
  endtask

  task automatic doReset();
    aresetn = 1'b0;
    idleReq();
    nextCycle();
    nextCycle();
    aresetn = 1'b1;
  endtask

  int awHs0, wHs0, bHs0;

  initial begin
    aresetn   = 1'b0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    m1_bready = 1'b1;
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    nextCycle();
    nextCycle();
    sampleNow();
    checkOutput("rst m0_arready", m0_arready, 0);
    checkOutput("rst s_arvalid", s_arvalid, 0);
    checkOutput("rst s_awvalid", s_awvalid, 0);
    checkOutput("rst s_wvalid", s_wvalid, 0);
    checkOutput("rst s_rready", s_rready, 0);
    checkOutput("rst s_bready", s_bready, 0);

    // Single M0 read
    nextCycle();
    aresetn = 1'b1;
    sampleNow();
    checkOutput("rd0 m0_arready c0", m0_arready, 1);
    checkOutput("rd0 m1_arready c0", m1_arready, 0);
    nextCycle();
    idleReq();
    sampleNow();
    checkOutput("rd0 s_arvalid c1", s_arvalid, 1);
    checkOutput("rd0 s_araddr c1", s_araddr, 64'h8000_0000);
    nextCycle();
    sampleNow();
    checkOutput("rd0 m0_rvalid c2", m0_rvalid, 1);
    checkOutput("rd0 m0_rdata c2", m0_rdata, 64'h00000297_00000413);
    checkOutput("rd0 m1_rvalid c2", m1_rvalid, 0);
    nextCycle();
    sampleNow();
    checkOutput("rd0 m0_rvalid c3", m0_rvalid, 0);

    // Simultaneous reads after reset
    doReset();
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("tie1 m0_arready", m0_arready, 1);
    checkOutput("tie1 m1_arready", m1_arready, 0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    nextCycle();
    sampleNow();
    checkOutput("tie1 m0_rvalid", m0_rvalid, 1);
    nextCycle();
    sampleNow();
    checkOutput("tie1 m1 granted next idle", m1_arready, 1);
    nextCycle();
    idleReq();
    nextCycle();
    sampleNow();
    checkOutput("tie1 m1_rvalid", m1_rvalid, 1);
    checkOutput("tie1 m1_rdata", m1_rdata, 64'h11223344_55667788);
    checkOutput("tie1 m0_rvalid during m1", m0_rvalid, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("tie2 m0_arready", m0_arready, 1);
    checkOutput("tie2 m1_arready", m1_arready, 0);
    nextCycle();
    idleReq();
    waitFor(0, "tie2 m0 rvalid");
    nextCycle();

    // M1 write with W delayed after AW, M0 waiting meanwhile
    wDelayCfg = 3;
    awHs0 = awHs;
    wHs0  = wHs;
    bHs0  = bHs;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_1000, 64'hDEADBEEF_CAFEBABE, 8'h0F);
    sampleNow();
    checkOutput("wr m1_awready", m1_awready, 1);
    checkOutput("wr m1_wready", m1_wready, 1);
    checkOutput("wr m1_arready", m1_arready, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("wr s_awvalid", s_awvalid, 1);
    checkOutput("wr s_awaddr", s_awaddr, 64'h8000_1000);
    checkOutput("wr s_wvalid", s_wvalid, 1);
    checkOutput("wr s_wdata", s_wdata, 64'hDEADBEEF_CAFEBABE);
    checkOutput("wr s_wstrb", s_wstrb, 64'h0F);
    waitFor(2, "wr m1_bvalid");
    checkOutput("wr m1_bresp", m1_bresp, 0);
    nextCycle();
    sampleNow();
    checkOutput("wr m0 granted after B", m0_arready, 1);
    checkOutput("wr aw handshakes", awHs - awHs0, 1);
    checkOutput("wr w handshakes", wHs - wHs0, 1);
    checkOutput("wr b handshakes", bHs - bHs0, 1);
    nextCycle();
    idleReq();
    waitFor(0, "wr m0 rvalid");
    nextCycle();

    // M1 write and read together, AW and W accepted in the same cycle
    wDelayCfg = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 1'b1, 32'h8000_1000, 64'h01234567_89ABCDEF, 8'hF0);
    sampleNow();
    checkOutput("wrrd m1_awready", m1_awready, 1);
    checkOutput("wrrd m1_arready", m1_arready, 0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    waitFor(2, "wrrd m1_bvalid");
    nextCycle();
    waitFor(3, "wrrd read grant");
    nextCycle();
    idleReq();
    waitFor(1, "wrrd m1_rvalid");
    checkOutput("wrrd read data", m1_rdata, 64'h01234567_CAFEBABE);
    nextCycle();

    // Backpressure on M0 R channel, M1 waiting; error response passes through
    rrespCfg  = 2'b10;
    m0_rready = 1'b0;
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("bp m0_arready", m0_arready, 1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      sampleNow();
      checkOutput("bp s_rready", s_rready, 0);
      checkOutput("bp m0_rvalid", m0_rvalid, 1);
      checkOutput("bp m1_arready", m1_arready, 0);
      nextCycle();
    end
    m0_rready = 1'b1;
    sampleNow();
    checkOutput("bp s_rready released", s_rready, 1);
    checkOutput("bp m0_rresp", m0_rresp, 64'h2);
    nextCycle();
    sampleNow();
    checkOutput("bp m1 granted", m1_arready, 1);
    nextCycle();
    idleReq();
    rrespCfg = 2'b00;
    waitFor(1, "bp m1_rvalid");
    nextCycle();

    // Reset while M0 read is in RD_DATA
    m0_rready = 1'b0;
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("mrst m0_arready", m0_arready, 1);
    nextCycle();
    idleReq();
    nextCycle();
    sampleNow();
    checkOutput("mrst m0_rvalid before", m0_rvalid, 1);
    aresetn = 1'b0;
    nextCycle();
    aresetn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    sampleNow();
    checkOutput("mrst m0_rvalid after", m0_rvalid, 0);
    checkOutput("mrst s_rready after", s_rready, 0);
    checkOutput("mrst s_arvalid after", s_arvalid, 0);
    checkOutput("mrst m1_arready", m1_arready, 1);
    m0_rready = 1'b1;
    nextCycle();
    idleReq();
    waitFor(1, "mrst m1_rvalid");
    checkOutput("mrst m1_rdata", m1_rdata, 64'h11223344_55667788);
    nextCycle();
    sampleNow();
    checkOutput("no grant while busy", badGrant, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
